prog_clk_divider: RTL and testbench

- Multi-channel, runtime-programmable clock divider for generating slow clocks and strobes from the system clock.
- Each channel produces a registered square wave (clk_out) and a one-cycle terminal-count strobe (tick).
- Divisors are written through a strobe interface and take effect only at the channel's next period boundary, so the output never glitches.
- Sits beside the system clock root and feeds slow peripherals, LED blinkers and sample-rate enables.

---
 rtl/clkdiv_pkg.sv | 22 ++
 rtl/clkdiv_channel.sv | 94 +++++++++
 rtl/prog_clk_divider.sv | 47 ++++
 tb/tb_prog_clk_divider.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// No logic of its own; functions are pure combinational helpers.
// No flow control; consumers call the helpers at elaboration or in comb logic.
package clkdiv_pkg;

  // Default counter/divisor width used by the top-level parameter.
  localparam int CNT_W_DEF = 16;

  // Smallest divisor that still yields a real high and low phase.
  localparam int MIN_DIV = 2;

  // Width of a channel index: never zero, even for a single channel.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Divisors 0 and 1 would collapse the period, so they are raised to MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, registered clk_out and tick.
// Latency: clk_out/tick reflect the counter value of the previous cycle (1 cycle).
// No backpressure: writes always land in the shadow; en=0 freezes the period.
// Optional ODD_DUTY50_EN adds a negedge flop that trims odd-N high phases to N/2.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_val,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] shd_div;
  logic [CNT_W-1:0] wr_clamped;
  logic [CNT_W:0]   high_len;
  logic             tc;
  logic             boundary;
  logic             clk_q;

  assign wr_clamped = CNT_W'(clamp_div(32'(wr_val)));
  // One extra bit so (N+1) cannot overflow for the largest divisor.
  assign high_len   = ({1'b0, act_div} + (CNT_W+1)'(1)) >> 1;
  assign tc         = (cnt == act_div - CNT_W'(1));
  // A period really ends only when the channel counts and sync does not override.
  assign boundary   = en & ~sync & tc;

  // Counter and registered outputs, all derived from the pre-edge count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      clk_q <= 1'b0;
      tick  <= 1'b0;
    end else if (sync) begin
      cnt   <= '0;
      clk_q <= 1'b1;
      tick  <= 1'b0;
    end else if (en) begin
      clk_q <= ({1'b0, cnt} < high_len);
      tick  <= tc;
      cnt   <= tc ? '0 : cnt + CNT_W'(1);
    end else begin
      tick  <= 1'b0;
    end
  end

  // Divisor bookkeeping: writes park in the shadow unless they coincide with the boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_div <= DEF_DIV;
      shd_div <= DEF_DIV;
      pend    <= 1'b0;
    end else if (wr_hit && boundary) begin
      act_div <= wr_clamped;
      shd_div <= wr_clamped;
      pend    <= 1'b0;
    end else if (wr_hit) begin
      shd_div <= wr_clamped;
      pend    <= 1'b1;
    end else if (boundary && pend) begin
      act_div <= shd_div;
      pend    <= 1'b0;
    end
  end

`ifdef ODD_DUTY50_EN
  logic clk_n;

  // Half-cycle-late copy of the posedge register, reset on the same rst.
  always_ff @(negedge clk) begin
    if (rst) clk_n <= 1'b0;
    else     clk_n <= clk_q;
  end

  // The posedge high phase is (N+1)/2 cycles; overlapping it with the
  // half-cycle-late copy removes half a cycle, leaving exactly N/2 high.
  assign clk_out = act_div[0] ? (clk_q & clk_n) : clk_q;
`else
  assign clk_out = clk_q;
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Latency: outputs registered, one cycle after the counter state they reflect.
// No backpressure: writes to channels >= NUM_CH are dropped; ODD_DUTY50_EN optional.
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          sync_all,
  input  logic                          div_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
  input  logic [CNT_W-1:0]              div_val,
  output logic [NUM_CH-1:0]             div_pend,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             tick
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // An out-of-range div_ch matches no channel, so the write simply vanishes.
    assign wr_hit[i] = div_wr && (div_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync_all),
      .wr_hit  (wr_hit[i]),
      .wr_val  (div_val),
      .pend    (div_pend[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider (5 channels so div_ch=5 is out of range).
// Expected outputs are queued when inputs are applied and checked one edge later.
// Period/high-phase lengths are also measured and checked against fixed values.
module tb_prog_clk_divider;

  localparam int NCH = 5;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync_all;
  logic           div_wr;
  logic [2:0]     div_ch;
  logic [CW-1:0]  div_val;
  logic [NCH-1:0] div_pend;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int total = 0;
  int bad   = 0;

  // reference state per channel
  int m_cnt [NCH];
  int m_act [NCH];
  int m_shd [NCH];
  int m_pend[NCH];
  int m_clk [NCH];
  int m_tick[NCH];

  // measured period statistics per channel
  int since   [NCH];
  int hi_cnt  [NCH];
  int last_per[NCH];
  int last_hi [NCH];

  logic [3*NCH-1:0] exp_q[$];

  prog_clk_divider #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_all (sync_all),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .div_pend (div_pend),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Predict the state after the coming posedge from the inputs now applied.
  task automatic model_edge();
    logic [3*NCH-1:0] e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      int  nv;
      int  hl;
      bit  hit;
      bit  tcb;
      bit  bnd;
      nv  = (div_val < 2) ? 2 : int'(div_val);
      hit = div_wr && (int'(div_ch) == c);
      tcb = (m_cnt[c] == m_act[c] - 1);
      bnd = en[c] && !sync_all && tcb;
      hl  = (m_act[c] + 1) / 2;
      if (rst) begin
        m_cnt[c] = 0; m_act[c] = 8; m_shd[c] = 8; m_pend[c] = 0;
        m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        if (sync_all) begin
          m_cnt[c] = 0; m_clk[c] = 1; m_tick[c] = 0;
        end else if (en[c]) begin
          m_clk[c]  = (m_cnt[c] < hl) ? 1 : 0;
          m_tick[c] = tcb ? 1 : 0;
          m_cnt[c]  = tcb ? 0 : m_cnt[c] + 1;
        end else begin
          m_tick[c] = 0;
        end
        if (hit && bnd) begin
          m_act[c] = nv; m_shd[c] = nv; m_pend[c] = 0;
        end else if (hit) begin
          m_shd[c] = nv; m_pend[c] = 1;
        end else if (bnd && m_pend[c] == 1) begin
          m_act[c] = m_shd[c]; m_pend[c] = 0;
        end
      end
      e[2*NCH + c] = m_pend[c][0];
      e[NCH + c]   = m_clk[c][0];
      e[c]         = m_tick[c][0];
    end
    exp_q.push_back(e);
  endtask

  // Advance n clocks: queue expectations, then check and measure at the negedge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3*NCH-1:0] e;
      model_edge();
      @(negedge clk);
      e = exp_q.pop_front();
      chk("div_pend", div_pend, e[3*NCH-1:2*NCH]);
      chk("clk_out",  clk_out,  e[2*NCH-1:NCH]);
      chk("tick",     tick,     e[NCH-1:0]);
      for (int c = 0; c < NCH; c++) begin
        if (rst) begin
          since[c] = 0; hi_cnt[c] = 0;
        end else begin
          since[c]++;
          if (clk_out[c]) hi_cnt[c]++;
          if (tick[c]) begin
            last_per[c] = since[c]; last_hi[c] = hi_cnt[c];
            since[c] = 0; hi_cnt[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic run_to_tick(input int c, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!tick[c] && n < 40);
    chk("tick_seen", tick[c], 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = '0; sync_all = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_act[c] = 8; m_shd[c] = 8; m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      since[c] = 0; hi_cnt[c] = 0; last_per[c] = 0; last_hi[c] = 0;
    end
    cyc(2);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);

    // default divisor 8 on channel 0
    rst = 1'b0; en = 5'b00001;
    run_to_tick(0, n);
    chk("first_tick_cycles", n, 8);
    run_to_tick(0, n);
    chk("n8_period", last_per[0], 8);
    chk("n8_high", last_hi[0], 4);

    // mid-period write of 5 at cnt=2
    cyc(2);
    div_wr = 1'b1; div_ch = 3'd0; div_val = 16'd5;
    cyc(1);
    div_wr = 1'b0;
    chk("pend_after_write", div_pend[0], 1);
    run_to_tick(0, n);
    chk("old_period_kept", last_per[0], 8);
    chk("pend_cleared", div_pend[0], 0);
    run_to_tick(0, n);
    chk("n5_period", last_per[0], 5);
    chk("n5_high", last_hi[0], 3);

    // write 3 exactly on the terminal-count edge (cnt=4 of N=5)
    cyc(4);
    div_wr = 1'b1; div_val = 16'd3;
    cyc(1);
    div_wr = 1'b0;
    chk("tc_write_tick", tick[0], 1);
    chk("tc_write_no_pend", div_pend[0], 0);
    run_to_tick(0, n);
    chk("n3_period", last_per[0], 3);
    chk("n3_high", last_hi[0], 2);

    // divisor 0 clamps to 2, written on the terminal-count edge (cnt=2 of N=3)
    cyc(2);
    div_wr = 1'b1; div_val = 16'd0;
    cyc(1);
    div_wr = 1'b0;
    run_to_tick(0, n);
    chk("n2_period", last_per[0], 2);
    chk("n2_high", last_hi[0], 1);

    // out-of-range channel is ignored
    div_wr = 1'b1; div_ch = 3'd5; div_val = 16'd7;
    cyc(1);
    div_wr = 1'b0;
    chk("bad_ch_no_pend", div_pend, 0);

    // two writes to channel 2 before its boundary: only 10 survives
    div_wr = 1'b1; div_ch = 3'd2; div_val = 16'd6;
    cyc(1);
    div_val = 16'd10;
    cyc(1);
    div_wr = 1'b0;
    en = 5'b00101;
    run_to_tick(2, n);
    run_to_tick(2, n);
    chk("last_write_period", last_per[2], 10);
    chk("last_write_high", last_hi[2], 5);

    // channel 1 frozen for 3 cycles mid-period
    en = 5'b00111;
    run_to_tick(1, n);
    cyc(3);
    en = 5'b00101;
    cyc(3);
    en = 5'b00111;
    run_to_tick(1, n);
    chk("stretched_period", last_per[1], 11);

    // sync_all restarts every channel high
    sync_all = 1'b1;
    cyc(1);
    sync_all = 1'b0;
    chk("sync_clk_out", clk_out, 5'b11111);
    chk("sync_tick", tick, 0);

    // reset at cnt=3 with a pending write on channel 1
    div_wr = 1'b1; div_ch = 3'd1; div_val = 16'd5;
    cyc(1);
    div_wr = 1'b0;
    cyc(2);
    chk("pend_before_rst", div_pend[1], 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_mid_clk_out", clk_out, 0);
    chk("rst_mid_pend", div_pend, 0);
    run_to_tick(1, n);
    chk("rst_first_tick", n, 8);
    run_to_tick(1, n);
    chk("rst_default_period", last_per[1], 8);
    chk("rst_default_high", last_hi[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
